// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch: state width and state encodings,
// used by the controller, the display driver and the time datapath.
package watch_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'b01;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'b10;
    localparam logic [STATE_W-1:0] ST_ADJ   = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_ADJ   = ST_ADJ
    } state_t;

endpackage

// File: rtl/watch_ctrl_edge_detect.sv
// Rising-edge detector for a debounced level; the history register tracks the
// input even during reset so a button held through reset yields no edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        prev <= level;
    end

    assign pulse = rst & level & ~prev;

endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch mode controller: chooses count/adjust/clear/hold each cycle and
// drives registered strobes and display levels for the datapath.
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               btn_pause,
    input  logic               btn_clear,
    input  logic               sw_adj,
    input  logic               sw_sel,
    input  logic               at_max,
    output logic               inc_sec,
    output logic               adj_min,
    output logic               adj_sec,
    output logic               clr,
    output logic               blink,
    output logic               running,
    output logic [STATE_W-1:0] state
);

    // state | meaning
    // IDLE  | stopped at 00:00 or after clear, waiting for start
    // RUN   | counting one second per tick_1hz
    // PAUSE | holding the current value
    // ADJ   | manual setting of minutes/seconds on tick_2hz

    state_t cur, nxt;
    logic   pause_edge, clear_edge;
    logic   n_inc, n_min, n_sec, n_clr;

    edge_detect u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_pause),
        .pulse (pause_edge)
    );

    edge_detect u_clear_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_clear),
        .pulse (clear_edge)
    );

    always_comb begin
        nxt   = cur;
        n_inc = 1'b0;
        n_min = 1'b0;
        n_sec = 1'b0;
        n_clr = 1'b0;
        if (clear_edge) begin
            n_clr = 1'b1;
            nxt   = sw_adj ? S_ADJ : S_IDLE;
        end else if (sw_adj && cur != S_ADJ) begin
            nxt = S_ADJ;
        end else if (cur == S_ADJ && !sw_adj) begin
            nxt = S_PAUSE;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (pause_edge) nxt = S_RUN;
                end
                S_RUN: begin
                    // a tick coinciding with pause is still counted
                    if (tick_1hz) begin
                        if (SATURATE != 0 && at_max) nxt = S_PAUSE;
                        else                         n_inc = 1'b1;
                    end
                    if (pause_edge) nxt = S_PAUSE;
                end
                S_PAUSE: begin
                    if (pause_edge) nxt = S_RUN;
                end
                S_ADJ: begin
                    if (tick_2hz) begin
                        n_min = ~sw_sel;
                        n_sec = sw_sel;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur     <= S_IDLE;
            inc_sec <= 1'b0;
            adj_min <= 1'b0;
            adj_sec <= 1'b0;
            clr     <= 1'b0;
            blink   <= 1'b0;
            running <= 1'b0;
        end else begin
            cur     <= nxt;
            inc_sec <= n_inc;
            adj_min <= n_min;
            adj_sec <= n_sec;
            clr     <= n_clr;
            blink   <= (nxt == S_ADJ);
            running <= (nxt == S_RUN);
        end
    end

    assign state = cur;

endmodule
